img_unpacket: RTL and testbench
===============================

# img_unpacket

Receive-side counterpart of the image packetizer. Reads packed frames (image words plus a one-line trailer) from a first-word-fall-through FIFO, for example on the DDR→EMMC or EMMC→NET readback path. Forwards image words downstream with backpressure and checks the trailer's parity word, pad words and frame-info words. Reports per-frame status when the frame completes.

## Interface
Parameters:
- LINE_SIZE, 1024, pixels per line; trailer length LINE_NUM = LINE_SIZE/PIX_PER_DATA words; LINE_NUM ≥ 8 required
- IMAGE_SIZE, 1024*1024, pixels per frame; WR_NUM = IMAGE_SIZE/PIX_PER_DATA words; WR_NUM ≤ 2^21 required
- PIX_SIZE, 8, bits per pixel; PIX_PER_DATA = 32/PIX_SIZE
- PKT_MODE, "2D", expected mode byte: "2D" → 0x00, anything else → 0x01

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous reset, active high
- fifo_rddata  in  32  FIFO head word; valid whenever fifo_empty=0
- fifo_empty  in  1  FIFO empty
- fifo_rden  out  1  pop; combinational
- unpack_en  in  1  permits start of a new frame; sampled only in IDLE
- data_out  out  32  image word
- data_out_valid  out  1  data_out valid
- data_out_ready  in  1  downstream accepts
- data_out_sof  out  1  high with the first image word of a frame
- frame_done  out  1  1-cycle pulse, frame trailer fully consumed
- frame_type_o  out  2  dw0[9:8] of the last frame
- frame_cnt_o  out  32  dw3 of the last frame
- parity_err  out  1  last frame parity mismatch
- fmt_err  out  1  last frame pad/info format violation
- seq_err  out  1  last frame counter ≠ expected

## Operation
- States: IDLE, RD_DATA, PARITY, FRAME_INFO, FLUSH, DONE. A 21-bit word counter wcnt is cleared in IDLE and DONE.
- IDLE: when unpack_en=1, go to RD_DATA. Clear the parity accumulator and the per-frame error scratch.
- RD_DATA:
  - fifo_rden = !fifo_empty && (!data_out_valid || data_out_ready).
  - Each pop loads data_out, sets data_out_valid and XORs the word into the accumulator. wcnt increments.
  - data_out_sof = 1 for the wcnt=0 word.
  - When the pop at wcnt=WR_NUM-1 happens, go to PARITY and reset wcnt to 0.
- Trailer states: fifo_rden = !fifo_empty. Trailer words are never forwarded, and data_out_ready is ignored. wcnt increments per pop and keeps counting across states.
- PARITY, wcnt 0–3:
  - word0 ≠ accumulator → parity_err scratch.
  - words 1–3 ≠ 0 → fmt_err scratch.
  - Go to FRAME_INFO after the pop at wcnt=3.
- FRAME_INFO, wcnt 4–7:
  - dw0: [7:0] must equal the mode byte and [31:16], [15:10] must be 0, else fmt_err. Capture [9:8] as the type.
  - dw1 and dw2 must be 0, else fmt_err.
  - dw3: capture as the counter; ≠ expected counter → seq_err.
  - Go to FLUSH after the pop at wcnt=7. If LINE_NUM=8, go straight to DONE.
- FLUSH, wcnt 8..LINE_NUM-1: pop and discard; contents are not checked. Go to DONE after the pop at wcnt=LINE_NUM-1.
- DONE (1 cycle):
  - frame_done=1.
  - parity_err, fmt_err, seq_err, frame_type_o and frame_cnt_o are updated from scratch and held until the next DONE.
  - Expected counter ← captured dw3 + 1, mod 2^32; this resyncs after a seq_err.
  - Then go to IDLE.
- Output register: data_out_valid clears when data_out_ready=1 and no new pop occurs. data_out holds its value while valid && !ready.
- unpack_en deasserted mid-frame: the current frame completes; no new frame starts.

## Timing
- Reset values: every output and register is 0, state is IDLE and the expected counter is 0. Reset mid-frame discards the partial frame; the FIFO is not drained.
- Pop at edge N → data_out/data_out_valid at N+1. Sustained throughput is 1 word/cycle with ready=1 and the FIFO non-empty.
- The FIFO is never popped while empty. fifo_empty stalls any state without error.
- IDLE→RD_DATA takes 1 cycle, so the first pop can occur the cycle after unpack_en is seen.
- frame_done occurs the cycle after the last flush pop. Minimum frame period is WR_NUM + LINE_NUM + 2 cycles.
- The last image word may still be held in data_out (ready=0) while trailer words are popped; this is legal.

## Test plan
Parameters are LINE_SIZE=48, IMAGE_SIZE=64, PIX_SIZE=8, so WR_NUM=16 and LINE_NUM=12.
1. FIFO holds words 1..16, then 0x10,0,0,0, then 0x00000100,0,0,0x0, then 4 zeros; unpack_en=1, ready=1 → data_out 1..16 on consecutive cycles, sof with word 1. frame_done with parity_err=0, fmt_err=0, seq_err=0, frame_type_o=1, frame_cnt_o=0.
2. Same as 1 but the parity word is 0x11 → parity_err=1, fmt_err=0. The next clean frame (dw3=1) clears parity_err.
3. Frames with dw3 = 0, 1, 5, 6 → seq_err = 0, 0, 1, 0.
4. data_out_ready low for 10 cycles mid-frame, FIFO with random empty gaps → at most one unaccepted word outstanding, order 1..16 preserved, no pop while empty.
5. dw0=0x00000101 under PKT_MODE="2D" → fmt_err=1. In a separate run, dw2=0xDEAD → fmt_err=1. In another run, PARITY pad word1=0x1 → fmt_err=1.
6. rst for 1 cycle after 5 image words → all outputs 0 the next cycle. Refill the FIFO with frame 1 (dw3=0) → decodes clean with seq_err=0.

Source files
------------

// File: rtl/img_unpacket_if.sv
// FIFO read side and forwarded image-word stream of the frame unpacketizer.
interface img_unpacket_if;
    logic [31:0] fifo_rddata;
    logic        fifo_empty;
    logic        fifo_rden;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        data_out_sof;

    modport master (
        input  fifo_rddata, fifo_empty, data_out_ready,
        output fifo_rden, data_out, data_out_valid, data_out_sof
    );

    modport slave (
        output fifo_rddata, fifo_empty, data_out_ready,
        input  fifo_rden, data_out, data_out_valid, data_out_sof
    );
endinterface

// File: rtl/img_unpacket.sv
// Unpacks image frames from a FWFT FIFO, forwarding image words and checking the trailer line.
// Pop to data_out in 1 cycle; one output register, pops stall while it is held; the trailer ignores ready.
module img_unpacket #(
    parameter int LINE_SIZE  = 1024,
    parameter int IMAGE_SIZE = 1024*1024,
    parameter int PIX_SIZE   = 8,
    parameter     PKT_MODE   = "2D"
) (
    input  logic        clk,
    input  logic        rst,
    img_unpacket_if.master bus,
    input  logic        unpack_en,
    output logic        frame_done,
    output logic [1:0]  frame_type_o,
    output logic [31:0] frame_cnt_o,
    output logic        parity_err,
    output logic        fmt_err,
    output logic        seq_err
);
    localparam int          PIX_PER_DATA = 32 / PIX_SIZE;
    localparam int          LINE_NUM     = LINE_SIZE / PIX_PER_DATA;
    localparam int          WR_NUM       = IMAGE_SIZE / PIX_PER_DATA;
    localparam logic [20:0] WR_LAST      = 21'(WR_NUM - 1);
    localparam logic [20:0] LINE_LAST    = 21'(LINE_NUM - 1);
    localparam logic [7:0]  MODE_BYTE    = (PKT_MODE == "2D") ? 8'h00 : 8'h01;

    typedef enum logic [2:0] {IDLE, RD_DATA, PARITY, FRAME_INFO, FLUSH, DONE} state_t;

    state_t      state;
    logic [20:0] wcnt;
    logic [31:0] acc;
    logic [31:0] exp_cnt;
    logic        par_s, fmt_s, seq_s;
    logic [1:0]  type_s;
    logic [31:0] cnt_s;

    logic        pop;
    logic        last_pop;
    logic        par_n, fmt_n, seq_n;
    logic [1:0]  type_n;
    logic [31:0] cnt_n;
    logic [31:0] rd;

    assign rd            = bus.fifo_rddata;
    assign bus.fifo_rden = pop;

    always_comb begin
        pop = 1'b0;
        case (state)
            RD_DATA:                   pop = !bus.fifo_empty && (!bus.data_out_valid || bus.data_out_ready);
            PARITY, FRAME_INFO, FLUSH: pop = !bus.fifo_empty;
            default:                   pop = 1'b0;
        endcase
    end

    // Scratch status including the word being popped this cycle, so the
    // final pop of the trailer can publish complete results on the same edge.
    always_comb begin
        par_n  = par_s;
        fmt_n  = fmt_s;
        seq_n  = seq_s;
        type_n = type_s;
        cnt_n  = cnt_s;
        if (pop && state == PARITY) begin
            if (wcnt[1:0] == 2'd0) par_n = par_s | (rd != acc);
            else                   fmt_n = fmt_s | (rd != 32'd0);
        end else if (pop && state == FRAME_INFO) begin
            case (wcnt[1:0])
                2'd0: begin
                    fmt_n  = fmt_s | (rd[7:0] != MODE_BYTE) | (rd[31:16] != 16'd0) | (rd[15:10] != 6'd0);
                    type_n = rd[9:8];
                end
                2'd1, 2'd2: fmt_n = fmt_s | (rd != 32'd0);
                default: begin
                    cnt_n = rd;
                    seq_n = (rd != exp_cnt);
                end
            endcase
        end
    end

    assign last_pop = pop && (((state == FRAME_INFO) && (wcnt == 21'd7) && (LINE_NUM == 8)) ||
                              ((state == FLUSH) && (wcnt == LINE_LAST)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            wcnt               <= 21'd0;
            acc                <= 32'd0;
            exp_cnt            <= 32'd0;
            par_s              <= 1'b0;
            fmt_s              <= 1'b0;
            seq_s              <= 1'b0;
            type_s             <= 2'd0;
            cnt_s              <= 32'd0;
            bus.data_out       <= 32'd0;
            bus.data_out_valid <= 1'b0;
            bus.data_out_sof   <= 1'b0;
            frame_done         <= 1'b0;
            frame_type_o       <= 2'd0;
            frame_cnt_o        <= 32'd0;
            parity_err         <= 1'b0;
            fmt_err            <= 1'b0;
            seq_err            <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (bus.data_out_ready) begin
                bus.data_out_valid <= 1'b0;
                bus.data_out_sof   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    wcnt <= 21'd0;
                    if (unpack_en) begin
                        state  <= RD_DATA;
                        acc    <= 32'd0;
                        par_s  <= 1'b0;
                        fmt_s  <= 1'b0;
                        seq_s  <= 1'b0;
                        type_s <= 2'd0;
                        cnt_s  <= 32'd0;
                    end
                end
                RD_DATA: begin
                    if (pop) begin
                        bus.data_out       <= rd;
                        bus.data_out_valid <= 1'b1;
                        bus.data_out_sof   <= (wcnt == 21'd0);
                        acc                <= acc ^ rd;
                        if (wcnt == WR_LAST) begin
                            wcnt  <= 21'd0;
                            state <= PARITY;
                        end else begin
                            wcnt <= wcnt + 21'd1;
                        end
                    end
                end
                PARITY, FRAME_INFO, FLUSH: begin
                    par_s  <= par_n;
                    fmt_s  <= fmt_n;
                    seq_s  <= seq_n;
                    type_s <= type_n;
                    cnt_s  <= cnt_n;
                    if (pop) wcnt <= wcnt + 21'd1;
                    if (last_pop) begin
                        state        <= DONE;
                        frame_done   <= 1'b1;
                        parity_err   <= par_n;
                        fmt_err      <= fmt_n;
                        seq_err      <= seq_n;
                        frame_type_o <= type_n;
                        frame_cnt_o  <= cnt_n;
                        exp_cnt      <= cnt_n + 32'd1;
                    end else if (pop && state == PARITY && wcnt == 21'd3) begin
                        state <= FRAME_INFO;
                    end else if (pop && state == FRAME_INFO && wcnt == 21'd7) begin
                        state <= FLUSH;
                    end
                end
                DONE: begin
                    wcnt  <= 21'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_img_unpacket.sv
// Directed bench for img_unpacket with WR_NUM=16, LINE_NUM=12 and a queue-backed FWFT FIFO.
module tb_img_unpacket;
    logic        clk = 1'b0;
    logic        rst;
    logic        unpack_en;
    logic        frame_done;
    logic [1:0]  frame_type_o;
    logic [31:0] frame_cnt_o;
    logic        parity_err, fmt_err, seq_err;

    img_unpacket_if bus();

    img_unpacket #(.LINE_SIZE(48), .IMAGE_SIZE(64), .PIX_SIZE(8), .PKT_MODE("2D")) dut (
        .clk(clk), .rst(rst), .bus(bus), .unpack_en(unpack_en), .frame_done(frame_done),
        .frame_type_o(frame_type_o), .frame_cnt_o(frame_cnt_o),
        .parity_err(parity_err), .fmt_err(fmt_err), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic        gap, rand_gap;
    int          cyc, c0, done_cyc;
    int          pop_bad, hold_bad;
    logic        stall_prev;
    logic [31:0] stall_dat;
    logic [31:0] acc_w[$];
    logic        acc_sof[$];
    int          acc_cyc[$];
    logic        done_seen;
    logic        d_par, d_fmt, d_seq;
    logic [1:0]  d_type;
    logic [31:0] d_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic refresh();
        bus.fifo_empty  = (q.size() == 0) || gap;
        bus.fifo_rddata = (q.size() == 0) ? 32'h0 : q[0];
    endtask

    // One clock: observe at the falling edge, apply FIFO pops just after the rising edge.
    task automatic step();
        logic pop;
        @(negedge clk);
        if (bus.fifo_rden && bus.fifo_empty) pop_bad++;
        pop = bus.fifo_rden && !bus.fifo_empty;
        if (bus.data_out_valid && bus.data_out_ready) begin
            acc_w.push_back(bus.data_out);
            acc_sof.push_back(bus.data_out_sof);
            acc_cyc.push_back(cyc);
        end
        if (stall_prev && (!bus.data_out_valid || bus.data_out !== stall_dat)) hold_bad++;
        stall_prev = bus.data_out_valid && !bus.data_out_ready;
        stall_dat  = bus.data_out;
        if (frame_done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
            d_par     = parity_err;
            d_fmt     = fmt_err;
            d_seq     = seq_err;
            d_type    = frame_type_o;
            d_cnt     = frame_cnt_o;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pop) void'(q.pop_front());
        if (rand_gap) gap = ($urandom_range(0, 2) == 0);
        refresh();
    endtask

    task automatic load_frame(input logic [31:0] par, input logic [31:0] p1, input logic [31:0] dw0,
                              input logic [31:0] dw2, input logic [31:0] dw3);
        for (int i = 1; i <= 16; i++) q.push_back(32'(i));
        q.push_back(par); q.push_back(p1);   q.push_back(32'h0); q.push_back(32'h0);
        q.push_back(dw0); q.push_back(32'h0); q.push_back(dw2); q.push_back(dw3);
        for (int i = 0; i < 4; i++) q.push_back(32'h0);
        refresh();
    endtask

    task automatic run_frame(input logic [31:0] par, input logic [31:0] p1, input logic [31:0] dw0,
                             input logic [31:0] dw2, input logic [31:0] dw3, input bit gaps, input bit stall);
        acc_w.delete(); acc_sof.delete(); acc_cyc.delete();
        done_seen = 1'b0;
        pop_bad   = 0;
        hold_bad  = 0;
        load_frame(par, p1, dw0, dw2, dw3);
        unpack_en = 1'b1;
        rand_gap  = gaps;
        c0        = cyc;
        for (int i = 0; i < 400 && !done_seen; i++) begin
            if (stall) bus.data_out_ready = !(i >= 8 && i < 18);
            step();
        end
        rand_gap = 1'b0;
        gap      = 1'b0;
        bus.data_out_ready = 1'b1;
        unpack_en = 1'b0;
        refresh();
        chk("frame_done_seen", 32'(done_seen), 32'd1);
        chk("frame_done_pulse", 32'(frame_done), 32'd0);
        chk("fifo_drained", q.size(), 32'd0);
    endtask

    task automatic check_words(input string tag);
        chk({tag, "_count"}, acc_w.size(), 32'd16);
        for (int i = 0; i < acc_w.size() && i < 16; i++) begin
            chk({tag, "_word"}, acc_w[i], 32'(i + 1));
            chk({tag, "_sof"}, 32'(acc_sof[i]), (i == 0) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic check_status(input string tag, input logic p, input logic f, input logic s,
                                input logic [1:0] t, input logic [31:0] c);
        chk({tag, "_parity_err"}, 32'(d_par), 32'(p));
        chk({tag, "_fmt_err"}, 32'(d_fmt), 32'(f));
        chk({tag, "_seq_err"}, 32'(d_seq), 32'(s));
        chk({tag, "_frame_type"}, 32'(d_type), 32'(t));
        chk({tag, "_frame_cnt"}, d_cnt, c);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        unpack_en = 1'b0;
        gap       = 1'b0;
        q.delete();
        refresh();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int seqv[4];
        int seqe[4];
        seqv = '{0, 1, 5, 6};
        seqe = '{0, 0, 1, 0};
        rst = 1'b1; unpack_en = 1'b0; gap = 1'b0; rand_gap = 1'b0; cyc = 0;
        stall_prev = 1'b0; stall_dat = 32'h0; done_seen = 1'b0;
        bus.data_out_ready = 1'b1;
        refresh();
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;

        // Reset state
        chk("rst_data_out", bus.data_out, 32'h0);
        chk("rst_valid", 32'(bus.data_out_valid), 32'd0);
        chk("rst_sof", 32'(bus.data_out_sof), 32'd0);
        chk("rst_rden", 32'(bus.fifo_rden), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_status", {26'd0, frame_type_o, parity_err, fmt_err, seq_err, 1'b0}, 32'h0);
        chk("rst_frame_cnt", frame_cnt_o, 32'h0);

        // Clean frame, full rate, latency and frame period
        run_frame(32'h10, 32'h0, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
        check_words("t1");
        if (acc_cyc.size() == 16) begin
            chk("t1_first_word_cycle", acc_cyc[0] - c0, 32'd2);
            chk("t1_last_word_cycle", acc_cyc[15] - c0, 32'd17);
        end
        chk("t1_done_cycle", done_cyc - c0, 32'd29);
        check_status("t1", 1'b0, 1'b0, 1'b0, 2'd1, 32'd0);

        // Parity mismatch, then cleared by the next clean frame
        do_reset();
        run_frame(32'h11, 32'h0, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
        check_status("t2a", 1'b1, 1'b0, 1'b0, 2'd1, 32'd0);
        run_frame(32'h10, 32'h0, 32'h100, 32'h0, 32'h1, 1'b0, 1'b0);
        check_status("t2b", 1'b0, 1'b0, 1'b0, 2'd1, 32'd1);

        // Sequence counter with a skip and resync
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_frame(32'h10, 32'h0, 32'h100, 32'h0, 32'(seqv[i]), 1'b0, 1'b0);
            chk("t3_seq_err", 32'(d_seq), 32'(seqe[i]));
            chk("t3_frame_cnt", d_cnt, 32'(seqv[i]));
        end

        // Backpressure and FIFO gaps
        do_reset();
        run_frame(32'h10, 32'h0, 32'h100, 32'h0, 32'h0, 1'b1, 1'b1);
        check_words("t4");
        chk("t4_pop_while_empty", pop_bad, 32'd0);
        chk("t4_hold_violation", hold_bad, 32'd0);
        check_status("t4", 1'b0, 1'b0, 1'b0, 2'd1, 32'd0);

        // Format violations
        do_reset();
        run_frame(32'h10, 32'h0, 32'h101, 32'h0, 32'h0, 1'b0, 1'b0);
        check_status("t5_mode", 1'b0, 1'b1, 1'b0, 2'd1, 32'd0);
        do_reset();
        run_frame(32'h10, 32'h0, 32'h100, 32'hDEAD, 32'h0, 1'b0, 1'b0);
        check_status("t5_dw2", 1'b0, 1'b1, 1'b0, 2'd1, 32'd0);
        do_reset();
        run_frame(32'h10, 32'h1, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
        check_status("t5_pad", 1'b0, 1'b1, 1'b0, 2'd1, 32'd0);

        // Reset mid-frame, then a clean frame from a fresh counter
        do_reset();
        run_frame(32'h10, 32'h0, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
        run_frame(32'h10, 32'h0, 32'h100, 32'h0, 32'h1, 1'b0, 1'b0);
        acc_w.delete(); acc_sof.delete(); acc_cyc.delete();
        load_frame(32'h10, 32'h0, 32'h100, 32'h0, 32'h0);
        unpack_en = 1'b1;
        for (int i = 0; i < 60 && acc_w.size() < 5; i++) step();
        chk("t6_words_before_rst", 32'(acc_w.size() >= 5), 32'd1);
        unpack_en = 1'b0;
        rst = 1'b1;
        q.delete();
        refresh();
        step();
        rst = 1'b0;
        chk("t6_data_out", bus.data_out, 32'h0);
        chk("t6_valid", 32'(bus.data_out_valid), 32'd0);
        chk("t6_sof", 32'(bus.data_out_sof), 32'd0);
        chk("t6_frame_done", 32'(frame_done), 32'd0);
        chk("t6_status", {26'd0, frame_type_o, parity_err, fmt_err, seq_err, 1'b0}, 32'h0);
        chk("t6_frame_cnt", frame_cnt_o, 32'h0);
        run_frame(32'h10, 32'h0, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
        check_words("t6");
        check_status("t6", 1'b0, 1'b0, 1'b0, 2'd1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
